// File: rtl/riscv_int_pkg.sv
// Shared types and constants for the multi-source interrupt controller.
package riscv_int_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    IRQ_PENDING = 2'd1,
    IRQ_DONE    = 2'd2
  } int_state_e;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

endpackage

// File: rtl/riscv_int_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the eligible vector wins.
module riscv_int_prio_enc #(
  parameter int NUM_IRQ = 32,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] elig,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  always_comb begin
    valid = |elig;
    id    = '0;
    // Scan downwards so the lowest index is the last (winning) assignment.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/riscv_int_controller_mc.sv
// Multi-line interrupt controller: latches edges, arbitrates by fixed priority
// and holds one (id, secure) request through the controller ack/kill handshake.
module riscv_int_controller_mc
  import riscv_int_pkg::*;
#(
  parameter int                  NUM_IRQ   = 32,
  parameter int                  ID_W      = $clog2(NUM_IRQ),
  parameter logic [NUM_IRQ-1:0]  EDGE_MASK = {NUM_IRQ{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_sec_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               m_irq_enable_i,
  input  logic               u_irq_enable_i,
  input  logic [1:0]         current_priv_lvl_i,
  output logic               irq_req_ctrl_o,
  output logic               irq_sec_ctrl_o,
  output logic [ID_W-1:0]    irq_id_ctrl_o,
  input  logic               ctrl_ack_i,
  input  logic               ctrl_kill_i,
  output logic [NUM_IRQ-1:0] irq_pending_o,
  output logic               irq_ack_o,
  output logic [ID_W-1:0]    irq_ack_id_o
);

  int_state_e         state_q;
  logic [NUM_IRQ-1:0] prev_q, pend_q;
  logic [NUM_IRQ-1:0] pending, gate, elig, clr;
  logic [ID_W-1:0]    id_q, win_id;
  logic               sec_q, req_q, win_vld, ack;

  assign ack = (state_q == IRQ_PENDING) && ctrl_ack_i;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    assign clr[i] = ack && (id_q == ID_W'(i));
  end

  // Set term is OR'd after the clear so a same-cycle re-trigger survives the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= irq_i;
      pend_q <= (irq_i & ~prev_q & EDGE_MASK) | (pend_q & ~clr);
    end
  end

  assign pending = (irq_i & ~EDGE_MASK) | pend_q;
  assign gate    = (current_priv_lvl_i == PRIV_M) ? {NUM_IRQ{m_irq_enable_i}}
                                                  : (irq_sec_i | {NUM_IRQ{u_irq_enable_i}});
  assign elig    = pending & irq_en_i & gate;

  riscv_int_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .elig  (elig),
    .valid (win_vld),
    .id    (win_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      sec_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (win_vld) begin
          state_q <= IRQ_PENDING;
          id_q    <= win_id;
          sec_q   <= irq_sec_i[win_id];
          req_q   <= 1'b1;
        end
        IRQ_PENDING: if (ctrl_ack_i) begin
          state_q <= IRQ_DONE;
          sec_q   <= 1'b0;
          req_q   <= 1'b0;
        end else if (ctrl_kill_i) begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
        IRQ_DONE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_ctrl_o = req_q;
  assign irq_sec_ctrl_o = sec_q;
  assign irq_id_ctrl_o  = id_q;
  assign irq_pending_o  = pending;
  assign irq_ack_o      = ack;
  assign irq_ack_id_o   = ack ? id_q : '0;

endmodule
